// File: rtl/pdu_io_pkg.sv
// Shared definitions for the PDU IO bus master: register map, opcodes, FSM encoding.
package pdu_io_pkg;

  localparam logic [7:0] ADDR_LED    = 8'h00;
  localparam logic [7:0] ADDR_SW     = 8'h04;
  localparam logic [7:0] ADDR_SEGRDY = 8'h08;
  localparam logic [7:0] ADDR_SEG    = 8'h0C;
  localparam logic [7:0] ADDR_SWXVLD = 8'h10;
  localparam logic [7:0] ADDR_SWX    = 8'h14;
  localparam logic [7:0] ADDR_CNT    = 8'h18;

  localparam logic [2:0] OP_WR_LED = 3'd0;
  localparam logic [2:0] OP_WR_SEG = 3'd1;
  localparam logic [2:0] OP_RD_SWX = 3'd2;
  localparam logic [2:0] OP_RD_CNT = 3'd3;
  localparam logic [2:0] OP_RD_RAW = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_POLL, ST_ACCESS, ST_RESP} state_e;

  function automatic logic op_is_read(input logic [2:0] op);
    return (op == OP_RD_SWX) || (op == OP_RD_CNT) || (op == OP_RD_RAW);
  endfunction

  function automatic logic [7:0] access_addr(input logic [2:0] op);
    case (op)
      OP_WR_LED: return ADDR_LED;
      OP_WR_SEG: return ADDR_SEG;
      OP_RD_SWX: return ADDR_SWX;
      OP_RD_CNT: return ADDR_CNT;
      default:   return ADDR_SW;
    endcase
  endfunction

endpackage

// File: rtl/pdu_io_master.sv
// Turns single client commands into PDU register transactions, with status
// polling, one-cycle strobes and an optional poll timeout. All outputs registered.
module pdu_io_master
  import pdu_io_pkg::*;
#(
  parameter int TIMEOUT = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  io_addr,
  output logic [31:0] io_dout,
  output logic        io_we,
  output logic        io_rd,
  input  logic [31:0] io_din
);

  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic [7:0]        io_addr_q, io_addr_d;
  logic [31:0]       io_dout_q, io_dout_d;
  logic              io_we_q, io_we_d;
  logic              io_rd_q, io_rd_d;
  logic              go_access;
  logic [2:0]        acc_op;
  logic [31:0]       acc_wdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    io_addr_d   = ADDR_SW;
    io_dout_d   = io_dout_q;
    io_we_d     = 1'b0;
    io_rd_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    go_access   = 1'b0;
    acc_op      = op_q;
    acc_wdata   = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          wdata_d   = cmd_wdata;
          acc_op    = cmd_op;
          acc_wdata = cmd_wdata;
          case (cmd_op)
            OP_WR_SEG: begin state_d = ST_POLL; io_addr_d = ADDR_SEGRDY; end
            OP_RD_SWX: begin state_d = ST_POLL; io_addr_d = ADDR_SWXVLD; end
            OP_WR_LED, OP_RD_CNT, OP_RD_RAW: go_access = 1'b1;
            default: begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = '0;
            end
          endcase
        end
      end
      ST_POLL: begin
        io_addr_d = io_addr_q;
        // A ready status wins over a timeout expiring in the same cycle.
        if (io_din[0]) begin
          go_access = 1'b1;
          cnt_d     = '0;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d     = ST_RESP;
          io_addr_d   = ADDR_SW;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = op_is_read(op_q) ? io_din : '0;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_access) begin
      state_d   = ST_ACCESS;
      io_addr_d = access_addr(acc_op);
      if (op_is_read(acc_op)) begin
        io_rd_d = 1'b1;
      end else begin
        io_we_d   = 1'b1;
        io_dout_d = acc_wdata;
      end
    end

    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      io_addr_q   <= ADDR_SW;
      io_dout_q   <= '0;
      io_we_q     <= 1'b0;
      io_rd_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      io_addr_q   <= io_addr_d;
      io_dout_q   <= io_dout_d;
      io_we_q     <= io_we_d;
      io_rd_q     <= io_rd_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign io_addr   = io_addr_q;
  assign io_dout   = io_dout_q;
  assign io_we     = io_we_q;
  assign io_rd     = io_rd_q;

endmodule

// File: doc/pdu_io_master.md
Name: pdu_io_master

Overview:
Hardware bus master that drives the PDU's IO bus on behalf of a simple command/response client, such as a CPU-side MMIO shim or board bring-up logic. It converts single high-level commands into PDU register transactions. Commands include "write LEDs", "write display once ready", "read switch data once valid" and "read counter". Status polling, single-cycle access strobes and timeouts are all handled here. It sits directly upstream of the PDU and owns io_addr/io_dout/io_we/io_rd.

Parameters:
TIMEOUT, 1000000, maximum POLL cycles before a command fails with rsp_err; 0 disables the timeout.
CNT_W, 20, width of the poll/timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  PDU bus clock; the same clock the PDU uses for its IO registers.
rstn  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command request.
cmd_ready  out  1  block can accept a command.
cmd_op  in  3  opcode: 0 WR_LED, 1 WR_SEG, 2 RD_SWX, 3 RD_CNT, 4 RD_RAW, 5-7 illegal.
cmd_wdata  in  32  write data for WR_LED/WR_SEG.
rsp_valid  out  1  response available.
rsp_ready  in  1  client accepts response.
rsp_data  out  32  read data; 0 for writes and errors.
rsp_err  out  1  1 = timeout or illegal opcode.
busy  out  1  state != IDLE.
io_addr  out  8  PDU register address.
io_dout  out  32  write data to PDU.
io_we  out  1  PDU write strobe.
io_rd  out  1  PDU read strobe.
io_din  in  32  PDU read data; combinational on io_addr.

Behaviour:
- PDU register map: 0x00 LED, 0x04 BTN/SW raw, 0x08 SEG_RDY (bit0), 0x0C SEG, 0x10 SWX_VLD (bit0), 0x14 SWX data, 0x18 CNT.
- All outputs are registered. Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0
  - io_addr=0x04, io_dout=0, io_we=0, io_rd=0
  - state=IDLE, counter=0
- FSM states: IDLE, POLL, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; io_addr=0x04; no strobes.
  - On cmd_valid at edge T: latch op and wdata.
  - WR_SEG goes to POLL with io_addr=0x08. RD_SWX goes to POLL with io_addr=0x10.
  - WR_LED, RD_CNT and RD_RAW go straight to ACCESS.
  - Illegal op goes to RESP with rsp_err=1, rsp_data=0.
- POLL:
  - io_addr holds the status address; io_din[0] is sampled every cycle.
  - If bit0=1: go to ACCESS. If bit0=0: counter increments.
  - If TIMEOUT!=0 and counter reaches TIMEOUT-1 while bit0=0: go to RESP with rsp_err=1, rsp_data=0, no PDU access.
  - Counter is cleared on leaving POLL.
- ACCESS (exactly one cycle):
  - WR_LED: io_addr=0x00, io_we=1, io_dout=wdata.
  - WR_SEG: io_addr=0x0C, io_we=1, io_dout=wdata.
  - RD_SWX: io_addr=0x14, io_rd=1. RD_CNT: io_addr=0x18, io_rd=1. RD_RAW: io_addr=0x04, io_rd=1.
  - Reads capture io_din into rsp_data at the end of ACCESS. Writes set rsp_data=0. rsp_err=0.
  - Next state is RESP.
- RESP:
  - io_addr returns to 0x04; strobes are 0; rsp_valid=1.
  - rsp_data and rsp_err are held stable until rsp_ready, then go to IDLE.
  - A new command cannot be accepted in the same cycle as rsp_ready; cmd_ready rises the cycle after.
- Latency, from accept edge T to rsp_valid high:
  - Direct ops: 2 cycles (ACCESS at T+1, RESP at T+2).
  - Polled ops with status already 1: 3 cycles.
  - io_we or io_rd is never asserted for more than one cycle per command. io_rd to 0x14 is issued only after SWX_VLD=1 was sampled.
- Simultaneous events:
  - cmd_valid is ignored unless in IDLE.
  - rsp_ready is ignored unless in RESP.
  - A status change in the same cycle as timeout expiry: bit0=1 wins and the access proceeds.
- Reset mid-operation: all outputs return asynchronously to reset values. Any in-flight strobe is dropped and no response is produced.

Decomposition:
- Shared package pdu_io_pkg holds:
  - register address localparams (ADDR_LED, ADDR_SW, ADDR_SEGRDY, ADDR_SEG, ADDR_SWXVLD, ADDR_SWX, ADDR_CNT);
  - opcode localparams;
  - 2-bit state encoding.
- No sub-module; single FSM plus counter.

Test Plan:
- WR_LED wdata=0x0000A5A5: io_we=1 and io_addr=0x00 for exactly one cycle at T+1. rsp_valid at T+2 with rsp_data=0, rsp_err=0.
- WR_SEG with PDU model SEG_RDY=0 for 5 cycles, then 1: exactly 5 poll cycles at io_addr=0x08, then one io_we at 0x0C with data 0x12345678, then rsp_valid.
- RD_SWX, SWX_VLD rises after 3 cycles, model SWX=0xDEADBEEF: single io_rd at 0x14. rsp_data=0xDEADBEEF, rsp_err=0. Model's vld clears.
- TIMEOUT=8, RD_SWX with SWX_VLD stuck 0: no io_rd ever issued. rsp_valid with rsp_err=1 and rsp_data=0 after 8 poll cycles.
- cmd_op=6: response next cycle with rsp_err=1, no strobes. Hold rsp_ready=0 for 4 cycles: rsp held stable. cmd_ready low until the cycle after the handshake.
- Assert rstn=0 during ACCESS of WR_LED: io_we drops immediately. After release: IDLE, cmd_ready=1, io_addr=0x04.
